// File: rtl/request_queue_if.sv
// Request/grant bundle shared by the two requesters and the request_queue arbiter.
// The arbiter uses the slave view: it samples R0/R1 and drives the registered grants.
interface request_queue_if;
    logic R0;
    logic R1;
    logic G0;
    logic G1;

    modport master (output R0, output R1, input G0, input G1);
    modport slave  (input R0, input R1, output G0, output G1);
endinterface

// File: rtl/request_queue.sv
// Two-requester arbiter that serves requests in arrival order, with requester 0 winning ties.
// One pending bit remembers a contested requester until it has been served once.
module request_queue (
    input  logic           clock,
    input  logic           reset,
    request_queue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN0   = 2'b01,
        OWN1   = 2'b10,
        UNUSED = 2'b11
    } owner_t;

    owner_t owner_q, owner_d;
    logic   pend_q,  pend_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        owner_d = IDLE;
        pend_d  = 1'b0;
        case (owner_q)
            IDLE: begin
                if (bus.R0) begin
                    owner_d = OWN0;
                    pend_d  = bus.R1;
                end else if (bus.R1) begin
                    owner_d = OWN1;
                end
            end
            // The pending entry is consumed on handoff even if the waiter has since dropped.
            OWN0: begin
                if (pend_q || bus.R1) begin
                    owner_d = OWN1;
                    pend_d  = bus.R0;
                end else if (bus.R0) begin
                    owner_d = OWN0;
                end
            end
            OWN1: begin
                if (pend_q || bus.R0) begin
                    owner_d = OWN0;
                    pend_d  = bus.R1;
                end else if (bus.R1) begin
                    owner_d = OWN1;
                end
            end
            default: begin
                owner_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Grants decode straight from the state register, so the unused encoding reads as no grant.
    assign bus.G0 = (owner_q == OWN0);
    assign bus.G1 = (owner_q == OWN1);

endmodule

// File: tb/tb_request_queue.sv
// Bench for request_queue: directed vector table, reset corner sequence, and
// randomized traffic checked against a queue-based model of the arbitration rules.
module tb_request_queue;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    request_queue_if bus ();

    request_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        bit    rst_n;
        bit    r0;
        bit    r1;
        bit    g0;
        bit    g1;
    } vec_t;

    vec_t vecs[$];

    // Reference model: current owner (-1 = nobody) and a queue of requesters waiting a turn.
    int model_owner;
    int waitq[$];

    function automatic void model_reset();
        model_owner = -1;
        waitq.delete();
    endfunction

    function automatic void model_step(bit r0, bit r1);
        bit req[2];
        int x;
        int y;
        bit queued;
        req[0] = r0;
        req[1] = r1;
        queued = 1'b0;
        if (model_owner < 0) begin
            if (r0) begin
                model_owner = 0;
                if (r1) waitq.push_back(1);
            end else if (r1) begin
                model_owner = 1;
            end
        end else begin
            x = model_owner;
            y = 1 - x;
            foreach (waitq[i]) if (waitq[i] == y) queued = 1'b1;
            waitq.delete();
            if (queued || req[y]) begin
                model_owner = y;
                if (req[x]) waitq.push_back(x);
            end else if (!req[x]) begin
                model_owner = -1;
            end
        end
    endfunction

    task automatic check(string name, bit eg0, bit eg1);
        checks++;
        if (bus.G0 !== eg0 || bus.G1 !== eg1) begin
            failures++;
            $display("FAIL %s: got G0=%b G1=%b, expected G0=%b G1=%b", name, bus.G0, bus.G1, eg0, eg1);
        end
    endtask

    task automatic add(string name, bit rst_n, bit r0, bit r1, bit g0, bit g1);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.r0 = r0; v.r1 = r1; v.g0 = g0; v.g1 = g1;
        vecs.push_back(v);
    endtask

    task automatic drive(bit rst_n, bit r0, bit r1);
        @(negedge clock);
        reset  = rst_n;
        bus.R0 = r0;
        bus.R1 = r1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r0;
        bit r1;
        bit rs;
        bus.R0 = 1'b0;
        bus.R1 = 1'b0;
        reset  = 1'b0;
        #1;
        check("reset_initial", 1'b0, 1'b0);

        add("reset_held",     0, 0, 0, 0, 0);
        add("reset_release",  1, 0, 0, 0, 0);
        add("tie_to_r0",      1, 1, 1, 1, 0);
        add("queued_r1",      1, 1, 0, 0, 1);
        add("back_to_r0",     1, 1, 0, 1, 0);
        add("hold_r0_a",      1, 1, 0, 1, 0);
        add("hold_r0_b",      1, 1, 0, 1, 0);
        add("hold_r0_c",      1, 1, 0, 1, 0);
        add("switch_to_r1",   1, 0, 1, 0, 1);
        add("switch_to_r0",   1, 1, 0, 1, 0);
        add("idle_again",     1, 0, 0, 0, 0);
        add("alt_1",          1, 1, 1, 1, 0);
        add("alt_2",          1, 1, 1, 0, 1);
        add("alt_3",          1, 1, 1, 1, 0);
        add("alt_4",          1, 1, 1, 0, 1);
        add("alt_5",          1, 1, 1, 1, 0);
        add("alt_6",          1, 1, 1, 0, 1);
        add("pending_r0",     1, 0, 0, 1, 0);
        add("drain_idle",     1, 0, 0, 0, 0);
        add("pulse_r1",       1, 0, 1, 0, 1);
        add("r1_released",    1, 0, 0, 0, 0);
        add("own0",           1, 1, 0, 1, 0);
        add("r1_contend",     1, 1, 1, 0, 1);
        add("r1_withdrawn",   1, 1, 0, 1, 0);
        add("r0_keeps",       1, 1, 0, 1, 0);
        add("release_all",    1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].r0, vecs[i].r1);
            @(posedge clock);
            #1;
            check(vecs[i].name, vecs[i].g0, vecs[i].g1);
        end

        // Asynchronous reset while requester 1 holds the grant, then re-arbitration of a tie.
        drive(1, 0, 1);
        @(posedge clock);
        #1;
        check("pre_async_g1", 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_clears", 1'b0, 1'b0);
        bus.R0 = 1'b1;
        bus.R1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            check("reset_holds_grants", 1'b0, 1'b0);
        end
        drive(1, 1, 1);
        @(posedge clock);
        #1;
        check("post_reset_tie", 1'b1, 1'b0);
        drive(1, 0, 0);
        @(posedge clock);
        #1;
        check("post_reset_queued", 1'b0, 1'b1);

        // Randomized traffic against the model; synchronise model with a reset first.
        drive(0, 0, 0);
        model_reset();
        @(posedge clock);
        for (int n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 49) != 0);
            r0 = ($urandom_range(0, 99) < 60);
            r1 = ($urandom_range(0, 99) < 45);
            drive(rs, r0, r1);
            if (!rs) model_reset();
            @(posedge clock);
            if (rs) model_step(r0, r1);
            #1;
            check("random", model_owner == 0, model_owner == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
